// File: rtl/fp16_add_arbiter.sv
// Round-robin arbiter that time-shares one combinational FP16 adder among four
// requesters: registers the winner's operands, waits ADD_LAT cycles, returns the sum.
module fp16_add_arbiter #(
    parameter int NREQ    = 4,
    parameter int ADD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [16*NREQ-1:0]   opa_flat,
    input  logic [16*NREQ-1:0]   opb_flat,
    output logic [15:0]          add_a,
    output logic [15:0]          add_b,
    input  logic [15:0]          add_o,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic [15:0]          res,
    output logic                 busy
);

    localparam int         PW       = $clog2(NREQ);
    localparam logic [3:0] LAT_INIT = 4'(ADD_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t          state, state_d;
    logic [PW-1:0]   ptr, ptr_d;
    logic [PW-1:0]   win, win_d;
    logic [PW-1:0]   pick;
    logic [3:0]      lat_cnt, lat_d;
    logic [NREQ-1:0] gnt_d, done_d;
    logic [15:0]     res_d, add_a_d, add_b_d;
    logic [15:0]     opa_arr [NREQ];
    logic [15:0]     opb_arr [NREQ];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            opa_arr[i] = opa_flat[16*i +: 16];
            opb_arr[i] = opb_flat[16*i +: 16];
        end
    end

    // First requester at or after ptr, wrapping; only consulted when |req.
    always_comb begin
        logic          found;
        logic [PW-1:0] idx;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = ptr + PW'(k);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    // NOTE: every signal gets its hold value before the case so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state;
        ptr_d   = ptr;
        win_d   = win;
        lat_d   = lat_cnt;
        gnt_d   = gnt;
        done_d  = '0;
        res_d   = res;
        add_a_d = add_a;
        add_b_d = add_b;
        case (state)
            S_IDLE: begin
                if (|req) begin
                    win_d   = pick;
                    gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << pick;
                    add_a_d = opa_arr[pick];
                    add_b_d = opb_arr[pick];
                    lat_d   = LAT_INIT;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (lat_cnt != 4'd0) begin
                    lat_d = lat_cnt - 4'd1;
                end else begin
                    res_d   = add_o;
                    done_d  = gnt;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                gnt_d   = '0;
                ptr_d   = win + 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples the pre-edge
    // value of the others, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            ptr     <= '0;
            win     <= '0;
            lat_cnt <= '0;
            gnt     <= '0;
            done    <= '0;
            res     <= '0;
            add_a   <= '0;
            add_b   <= '0;
        end else begin
            state   <= state_d;
            ptr     <= ptr_d;
            win     <= win_d;
            lat_cnt <= lat_d;
            gnt     <= gnt_d;
            done    <= done_d;
            res     <= res_d;
            add_a   <= add_a_d;
            add_b   <= add_b_d;
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_fp16_add_arbiter.sv
// Scoreboard bench for fp16_add_arbiter: ADD_LAT=1 and ADD_LAT=3 instances share
// clock and reset; a table-driven adder model stands in for the shared adder.
module tb_fp16_add_arbiter;

    typedef struct {
        logic [3:0]  done;
        logic [15:0] res;
        int          cyc;
    } exp_t;

    logic         clk;
    logic         rst;
    logic [3:0]   d1_req, d3_req;
    logic [63:0]  d1_opa, d1_opb, d3_opa, d3_opb;
    logic [15:0]  d1_add_a, d1_add_b, d1_add_o, d3_add_a, d3_add_b, d3_add_o;
    logic [3:0]   d1_gnt, d1_done, d3_gnt, d3_done;
    logic [15:0]  d1_res, d3_res;
    logic         d1_busy, d3_busy;

    int    ntests = 0;
    int    nfail  = 0;
    int    cyc    = 0;
    exp_t  q1[$], q3[$];
    exp_t  e1, e3;
    logic [15:0] sum_tab [4];

    function automatic logic [15:0] fp16_model(input logic [15:0] a, input logic [15:0] b);
        case ({a, b})
            32'h3C00_4000: return 16'h4200;   // 1.0 + 2.0
            32'h3C00_3E00: return 16'h4100;   // 1.0 + 1.5
            32'h4400_4000: return 16'h4600;   // 4.0 + 2.0
            32'h3800_3800: return 16'h3C00;   // 0.5 + 0.5
            32'h4000_4000: return 16'h4400;   // 2.0 + 2.0
            default:       return 16'hDEAD;
        endcase
    endfunction

    assign d1_add_o = fp16_model(d1_add_a, d1_add_b);
    assign d3_add_o = fp16_model(d3_add_a, d3_add_b);

    fp16_add_arbiter #(.NREQ(4), .ADD_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .req(d1_req), .opa_flat(d1_opa), .opb_flat(d1_opb),
        .add_a(d1_add_a), .add_b(d1_add_b), .add_o(d1_add_o),
        .gnt(d1_gnt), .done(d1_done), .res(d1_res), .busy(d1_busy)
    );

    fp16_add_arbiter #(.NREQ(4), .ADD_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .req(d3_req), .opa_flat(d3_opa), .opb_flat(d3_opb),
        .add_a(d3_add_a), .add_b(d3_add_b), .add_o(d3_add_o),
        .gnt(d3_gnt), .done(d3_done), .res(d3_res), .busy(d3_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && d1_done != 4'b0000) begin
            if (q1.size() == 0) begin
                ntests++;
                nfail++;
                $display("FAIL d1_unexpected_done: got %b expected none (cycle %0d)", d1_done, cyc);
            end else begin
                e1 = q1.pop_front();
                check("d1_done", 32'(d1_done), 32'(e1.done));
                check("d1_res",  32'(d1_res),  32'(e1.res));
                check("d1_cycle", cyc, e1.cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && d3_done != 4'b0000) begin
            if (q3.size() == 0) begin
                ntests++;
                nfail++;
                $display("FAIL d3_unexpected_done: got %b expected none (cycle %0d)", d3_done, cyc);
            end else begin
                e3 = q3.pop_front();
                check("d3_done", 32'(d3_done), 32'(e3.done));
                check("d3_res",  32'(d3_res),  32'(e3.res));
                check("d3_cycle", cyc, e3.cyc);
            end
        end
    end

    initial begin
        int         c;
        logic [3:0] oh;

        rst    = 1'b1;
        d1_req = 4'b0000;
        d3_req = 4'b0000;
        // packing {req3, req2, req1, req0}
        d1_opa = {16'h3800, 16'h4400, 16'h3C00, 16'h3C00};
        d1_opb = {16'h3800, 16'h4000, 16'h3E00, 16'h4000};
        d3_opa = {16'h0000, 16'h4000, 16'h0000, 16'h0000};
        d3_opb = {16'h0000, 16'h4000, 16'h0000, 16'h0000};
        sum_tab[0] = 16'h4200;
        sum_tab[1] = 16'h4100;
        sum_tab[2] = 16'h4600;
        sum_tab[3] = 16'h3C00;

        repeat (2) @(negedge clk);
        check("rst_gnt",   32'(d1_gnt),   32'h0);
        check("rst_done",  32'(d1_done),  32'h0);
        check("rst_res",   32'(d1_res),   32'h0);
        check("rst_add_a", 32'(d1_add_a), 32'h0);
        check("rst_add_b", 32'(d1_add_b), 32'h0);
        check("rst_busy",  32'(d1_busy),  32'h0);
        rst = 1'b0;

        // single request: 1.0 + 2.0
        @(negedge clk);
        c = cyc;
        d1_req = 4'b0001;
        q1.push_back('{4'b0001, 16'h4200, c + 2});
        @(negedge clk);
        check("single_gnt",  32'(d1_gnt),  32'h1);
        check("single_busy", 32'(d1_busy), 32'h1);
        @(negedge clk);
        check("single_busy_done", 32'(d1_busy), 32'h1);
        d1_req = 4'b0000;
        @(negedge clk);
        check("single_busy_end", 32'(d1_busy), 32'h0);
        check("single_gnt_end",  32'(d1_gnt),  32'h0);

        // async reset while BUSY (ptr is 1 here, so requester 2 wins)
        @(negedge clk);
        d1_req = 4'b0100;
        @(posedge clk);
        #2;
        check("rst_pre_gnt", 32'(d1_gnt), 32'h4);
        rst = 1'b1;
        #1;
        check("async_gnt",   32'(d1_gnt),   32'h0);
        check("async_done",  32'(d1_done),  32'h0);
        check("async_busy",  32'(d1_busy),  32'h0);
        check("async_add_a", 32'(d1_add_a), 32'h0);
        check("async_add_b", 32'(d1_add_b), 32'h0);
        check("async_res",   32'(d1_res),   32'h0);
        d1_req = 4'b0000;
        @(negedge clk);
        rst = 1'b0;

        // all four requesting: order must restart at 0 after reset
        @(negedge clk);
        c = cyc;
        d1_req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            oh = 4'b0001 << (k % 4);
            q1.push_back('{oh, sum_tab[k % 4], c + 2 + 3 * k});
        end
        repeat (14) @(negedge clk);
        d1_req = 4'b0000;
        @(negedge clk);
        check("sim_busy_end", 32'(d1_busy), 32'h0);

        // fairness: 0 keeps requesting, 2 joins once and must be next
        @(negedge clk);
        c = cyc;
        d1_req = 4'b0001;
        q1.push_back('{4'b0001, 16'h4200, c + 2});
        q1.push_back('{4'b0100, 16'h4600, c + 5});
        q1.push_back('{4'b0001, 16'h4200, c + 8});
        @(negedge clk);
        d1_req = 4'b0101;
        repeat (4) @(negedge clk);
        d1_req = 4'b0001;
        repeat (3) @(negedge clk);
        d1_req = 4'b0000;

        // idle hold
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("idle_res",  32'(d1_res),  32'h4200);
            check("idle_done", 32'(d1_done), 32'h0);
            check("idle_gnt",  32'(d1_gnt),  32'h0);
            check("idle_busy", 32'(d1_busy), 32'h0);
        end

        // ADD_LAT=3: 2.0 + 2.0 on requester 2
        @(negedge clk);
        c = cyc;
        d3_req = 4'b0100;
        q3.push_back('{4'b0100, 16'h4400, c + 4});
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("lat3_add_a", 32'(d3_add_a), 32'h4000);
            check("lat3_add_b", 32'(d3_add_b), 32'h4000);
            check("lat3_gnt",   32'(d3_gnt),   32'h4);
            check("lat3_busy",  32'(d3_busy),  32'h1);
        end
        @(negedge clk);
        check("lat3_busy_done", 32'(d3_busy), 32'h1);
        d3_req = 4'b0000;
        @(negedge clk);
        check("lat3_busy_end", 32'(d3_busy), 32'h0);
        check("lat3_res",      32'(d3_res),  32'h4400);

        repeat (3) @(negedge clk);
        check("d1_queue_drained", q1.size(), 0);
        check("d3_queue_drained", q3.size(), 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/fp16_add_arbiter.md
Name: fp16_add_arbiter

Overview:
Round-robin arbiter and sequencer that shares one combinational FP16 (1-5-10) adder among 4 requesters. It registers the winning requester's operands onto the adder inputs and waits a configurable number of cycles. It then captures the adder output and returns it to the winner with a one-cycle done pulse. It sits between the compute clients and the single adder instance, so the adder needs no handshake of its own.

Parameters:
- NREQ, 4: number of requesters; fixed at 4 for this revision (flattened buses sized to 4).
- ADD_LAT, 1: cycles operands are held on the adder before the result is captured (1..15). 1 suits a purely combinational adder.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  request per requester; level-held until that requester's done pulse.
- opa_flat  input  64  operand A; requester i drives bits [16i+15:16i].
- opb_flat  input  64  operand B; same packing as opa_flat.
- add_a  output  16  registered operand A to the shared adder.
- add_b  output  16  registered operand B to the shared adder.
- add_o  input  16  combinational sum from the shared adder.
- gnt  output  4  one-hot grant; high in BUSY and DONE for the winner, else 0.
- done  output  4  one-cycle pulse to the winner; res is valid in the same cycle.
- res  output  16  captured sum; holds its value until the next capture.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async, immediate): state=IDLE, ptr=0, gnt=0, done=0, res=0, add_a=0, add_b=0, lat_cnt=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE, req==0: stay in IDLE; all outputs hold except done=0.
- IDLE, req!=0: winner w = first set bit searching ptr, ptr+1, ... mod 4.
  - On the next edge: add_a <= opa[w], add_b <= opb[w], gnt <= onehot(w), lat_cnt <= ADD_LAT-1, go to BUSY.
- BUSY, lat_cnt!=0: decrement lat_cnt; add_a and add_b stay stable.
- BUSY, lat_cnt==0: on the edge, res <= add_o, done <= onehot(w), go to DONE.
- DONE: done is high for exactly this cycle.
  - On the next edge: done=0, gnt=0, ptr <= (w+1) mod 4, go to IDLE.
- Latency: req seen in IDLE at edge t -> done high during cycle t+ADD_LAT+1. With ADD_LAT=1 the issue rate is one operation per 3 cycles.
- Requester protocol:
  - Operands must stay stable while req is high.
  - The requester must deassert req or present new operands by the edge that ends its done cycle.
  - A req still high in the DONE cycle is treated as a new request at the next IDLE arbitration.
- Requests arriving during BUSY or DONE wait; no request is ever dropped.
- A requester dropping req during BUSY does not abort the operation: the result is still captured and done still pulses.
- Simultaneous requests: exactly one grant. Rotation (ptr) guarantees each waiting requester is served within 4 operations.
- No arithmetic is done in this block. add_o is passed to res unmodified, including 0x0000 on exponent underflow from the adder.
- Reset mid-operation returns to IDLE at once. The pending result is lost, no done pulse is issued, and ptr returns to 0.

Test Plan:
- Single request, ADD_LAT=1: req=0001, opa0=0x3C00 (1.0), opb0=0x4000 (2.0). Required: gnt=0001 one cycle after the request; done=0001 and res=0x4200 (3.0) two cycles after; busy high for 2 cycles.
- Simultaneous requests: req=1111 held continuously, each requester with distinct operands (e.g. opa1=0x3C00, opb1=0x3E00 -> 0x4100). Required: grant order 0,1,2,3,0; each done carries its own requester's sum; one done every 3 cycles.
- Rotation fairness: requester 0 re-requests immediately after each done while requester 2 requests once. Required: requester 2 is served directly after requester 0's first operation, not starved.
- ADD_LAT=3, req=0100 with 0x4000+0x4000. Required: add_a and add_b stable for 3 cycles; done=0100 at cycle 4 after the request; res=0x4400 (4.0).
- Async reset asserted in BUSY. Required: outputs cleared immediately with no clock edge, no done pulse, and the next arbitration starts from ptr=0.
- Idle hold: after one completed operation, req=0000 for 10 cycles. Required: res keeps its last value; done, gnt and busy stay 0.
